// File: rtl/alu_decode_queue_pkg.sv
// Shared ALU encodings: control codes, alu_op classes and the R-type opcode.
// Used by the ALU datapath and by the decode queue.
package alu_decode_queue_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_ARITH  = 2'b10,
        ALUOP_PASS   = 2'b11
    } alu_op_e;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

    typedef struct packed {
        logic [3:0] control;
        logic       illegal;
    } decoded_t;

endpackage

// File: rtl/alu_decode_queue_decoder.sv
// Combinational alu_op/funct decode into an ALU control code plus illegal flag.
module alu_op_decoder
    import alu_decode_queue_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] control,
    output logic       illegal
);

    always_comb begin
        control = ALU_PASS;
        illegal = 1'b0;
        case (alu_op_e'(alu_op))
            ALUOP_MEM:    control = ALU_ADD;
            ALUOP_BRANCH: control = ALU_SUB;
            ALUOP_PASS:   control = ALU_PASS;
            ALUOP_ARITH: begin
                case (funct3)
                    3'b000:  control = (opcode == OPCODE_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b110:  control = ALU_OR;
                    3'b111:  control = ALU_AND;
                    default: begin
                        control = ALU_PASS;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: control = ALU_PASS;
        endcase
    end

endmodule

// File: rtl/alu_decode_queue.sv
// Decode-at-push FIFO: stores decoded {control, illegal} pairs and presents the head
// to the ALU stage with a valid/ready handshake on both sides.
module alu_decode_queue
    import alu_decode_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] control,
    output logic       illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    decoded_t          mem [DEPTH];
    decoded_t          dec;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;

    alu_op_decoder u_dec (
        .alu_op   (alu_op),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .control  (dec.control),
        .illegal  (dec.illegal)
    );

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head comes straight from storage; an empty queue shows the idle PASS code.
    assign control = out_valid ? mem[rptr].control : ALU_PASS;
    assign illegal = out_valid ? mem[rptr].illegal : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= dec;
    end

endmodule

// File: tb/tb_alu_decode_queue.sv
// Scoreboard bench for alu_decode_queue: driver pushes expected decodes, monitor pops and compares.
module tb_alu_decode_queue;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] alu_op = 2'b00;
    logic [6:0] opcode = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] control;
    logic       illegal;

    int tests = 0;
    int fails = 0;

    logic [4:0] exp_q[$];
    logic       prev_hold = 1'b0;
    logic [4:0] prev_out = 5'b0;
    logic       accepted;

    alu_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .control   (control),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference decode written straight from the instruction-class table.
    function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [6:0] opc,
                                              input logic [2:0] f3, input logic f7);
        logic [4:0] r;
        if (op == 2'b00)      r = {4'b0010, 1'b0};
        else if (op == 2'b01) r = {4'b0110, 1'b0};
        else if (op == 2'b11) r = {4'b1111, 1'b0};
        else if (f3 == 3'b000)
            r = (opc == 7'b0110011 && f7) ? {4'b0110, 1'b0} : {4'b0010, 1'b0};
        else if (f3 == 3'b110) r = {4'b0001, 1'b0};
        else if (f3 == 3'b111) r = {4'b0000, 1'b0};
        else                   r = {4'b1111, 1'b1};
        return r;
    endfunction

    // Monitor: compares handshake flags with the model occupancy and pops on consume.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            check("out_valid", int'(out_valid), int'(exp_q.size() > 0));
            check("in_ready", int'(in_ready), int'(exp_q.size() < DEPTH));
            if (!out_valid)
                check("idle_out", int'({control, illegal}), int'(5'b11110));
            if (prev_hold && out_valid)
                check("hold_stable", int'({control, illegal}), int'(prev_out));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("underflow", 1, 0);
                end else begin
                    check("head", int'({control, illegal}), int'(exp_q.pop_front()));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {control, illegal};
        end
    end

    // Driver: called at posedge+1, drives one cycle, records an accepted push.
    task automatic drive_cycle(input logic v, input logic [1:0] op, input logic [6:0] opc,
                               input logic [2:0] f3, input logic f7, input logic rdy);
        in_valid  = v;
        alu_op    = op;
        opcode    = opc;
        funct3    = f3;
        funct7b5  = f7;
        out_ready = rdy;
        @(negedge clk);
        #1;
        accepted = v && in_ready;
        if (accepted)
            exp_q.push_back(ref_decode(op, opc, f3, f7));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, 2'b00, 7'b0, 3'b0, 1'b0, rdy);
    endtask

    initial begin
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_control", int'(control), 4'hf);
        check("rst_illegal", int'(illegal), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SUB R-type pushed on the first edge after reset release, then ADDI and illegal funct3
        drive_cycle(1'b1, 2'b10, 7'b0110011, 3'b000, 1'b1, 1'b1);
        check("first_push_accepted", int'(accepted), 1);
        drive_cycle(1'b1, 2'b10, 7'b0010011, 3'b000, 1'b1, 1'b1);
        drive_cycle(1'b1, 2'b10, 7'b0010011, 3'b001, 1'b0, 1'b1);
        drive_cycle(1'b1, 2'b00, 7'b0000011, 3'b010, 1'b0, 1'b1);
        drive_cycle(1'b1, 2'b01, 7'b1100011, 3'b000, 1'b0, 1'b1);
        drive_cycle(1'b1, 2'b11, 7'b0110111, 3'b000, 1'b0, 1'b1);
        idle(1'b1, 3);

        // Fill with ADD, OR; AND must be refused while full
        drive_cycle(1'b1, 2'b10, 7'b0110011, 3'b000, 1'b0, 1'b0);
        drive_cycle(1'b1, 2'b10, 7'b0110011, 3'b110, 1'b0, 1'b0);
        drive_cycle(1'b1, 2'b10, 7'b0110011, 3'b111, 1'b0, 1'b0);
        check("full_refuses_push", int'(accepted), 0);
        idle(1'b0, 2);
        idle(1'b1, 3);

        // Count 1, then simultaneous push/pop for 8 cycles
        drive_cycle(1'b1, 2'b10, 7'b0110011, 3'b110, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 2'b10, 7'b0110011, (i % 2 == 0) ? 3'b111 : 3'b000, i[0], 1'b1);
            check("stream_accept", int'(accepted), 1);
        end
        idle(1'b1, 2);

        // Asynchronous reset while full
        drive_cycle(1'b1, 2'b00, 7'b0, 3'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 2'b01, 7'b0, 3'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        check("pre_rst_full", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_control", int'(control), 4'hf);
        check("arst_illegal", int'(illegal), 0);
        check("arst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_cycle(1'b1, 2'b10, 7'b0110011, 3'b111, 1'b0, 1'b0);
        check("post_rst_push", int'(accepted), 1);
        idle(1'b1, 2);

        // Random traffic against the reference queue
        for (int i = 0; i < 1000; i++) begin
            logic [6:0] opc;
            case ($urandom_range(0, 2))
                0:       opc = 7'b0110011;
                1:       opc = 7'b0010011;
                default: opc = 7'($urandom);
            endcase
            drive_cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), opc, 3'($urandom),
                        1'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        idle(1'b1, DEPTH + 2);
        check("drained", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_decode_queue.md
ALU_DECODE_QUEUE -- requirements
Module: alu_decode_queue

Interface
REQ-001 Parameter: DEPTH, 2, number of buffered decoded entries; legal values 2, 4 or 8.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream offers a decode request.
REQ-005 Port: in_ready  output  1  queue accepts a request this cycle.
REQ-006 Port: alu_op  input  2  instruction class: 00 load/store, 01 branch, 10 R/I arithmetic, 11 pass-through.
REQ-007 Port: opcode  input  7  instruction opcode field.
REQ-008 Port: funct3  input  3  instruction funct3 field.
REQ-009 Port: funct7b5  input  1  instruction bit 30.
REQ-010 Port: out_valid  output  1  head entry is valid.
REQ-011 Port: out_ready  input  1  ALU stage consumes the head entry.
REQ-012 Port: control  output  4  ALU control code of the head entry.
REQ-013 Port: illegal  output  1  head entry decoded from an unsupported encoding.

Function
REQ-014 Decode mapping SHALL be: alu_op 00 -> 0010 (ADD); alu_op 01 -> 0110 (SUB); alu_op 11 -> 1111 (pass a), illegal 0.
REQ-015 For alu_op 10: funct3 000 -> 0110 if opcode 0110011 and funct7b5 1, else 0010; funct3 110 -> 0001 (OR); funct3 111 -> 0000 (AND).
REQ-016 For alu_op 10 with any other funct3: control 1111, illegal 1.
REQ-017 Decode SHALL occur at push; the queue stores the decoded {control, illegal} pair, not raw fields.
REQ-018 Push occurs when in_valid and in_ready are both 1; pop occurs when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be 1 when count < DEPTH, 0 when full; no same-cycle pass-through when full.
REQ-020 out_valid SHALL be 1 when count > 0; control/illegal are the head entry, driven from registers.
REQ-021 Latency: a request pushed in cycle N is visible at outputs in cycle N+1 at the earliest; no combinational bypass when empty.
REQ-022 Simultaneous push and pop when 0 < count < DEPTH: count unchanged, order preserved.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; entries SHALL leave in FIFO order.
REQ-024 While out_valid is 1 and out_ready is 0, control and illegal SHALL hold stable.
REQ-025 When out_valid is 0, control SHALL read 1111 and illegal 0.

Reset
REQ-026 On rst assertion, immediately and asynchronously: count 0, pointers 0, out_valid 0, in_ready 1, control 1111, illegal 0.
REQ-027 Reset mid-operation SHALL discard all buffered entries; no push or pop is recorded in the reset cycle.
REQ-028 The first push SHALL be accepted on the first rising clk edge after rst deasserts.

Structure
REQ-029 ALU control codes (AND 0000, OR 0001, ADD 0010, SUB 0110, PASS 1111), alu_op encodings and the R-type opcode constant SHALL reside in a shared package used by the ALU and this block.
REQ-030 The decode mapping SHALL be a combinational sub-module named alu_op_decoder; the storage and handshake logic SHALL remain in alu_decode_queue.

Verification
REQ-031 Reset then push alu_op 10, opcode 0110011, funct3 000, funct7b5 1 -> next cycle out_valid 1, control 0110, illegal 0.
REQ-032 Push alu_op 10, opcode 0010011, funct3 000, funct7b5 1 (ADDI) -> control 0010; push funct3 001 -> control 1111, illegal 1.
REQ-033 DEPTH 2, out_ready 0, push ADD, OR, AND -> in_ready 0 after two pushes, third not accepted; release out_ready -> outputs 0010 then 0001.
REQ-034 Count 1, push and pop in the same cycle for 8 cycles -> out_valid stays 1, outputs follow push order, count stays 1.
REQ-035 Queue full, assert rst mid-cycle -> out_valid 0, control 1111, in_ready 1 without waiting for a clk edge.
REQ-036 Random push/pop for 1000 cycles against a reference queue model -> identical output sequence, no overflow or underflow.
